// File: rtl/pipe_pkg.sv
// Shared pipeline constants and the hazard tuple that stage registers and the hazard unit exchange.
package pipe_pkg;

   localparam int unsigned T_W_DEFAULT       = 4;
   localparam int unsigned TUSE_NONE_DEFAULT = 4;
   localparam logic [4:0]  GPR_ZERO          = 5'd0;

   typedef struct packed {
      logic [4:0]             dst_addr;
      logic [T_W_DEFAULT-1:0] tnew;
      logic [T_W_DEFAULT-1:0] rs_tuse;
      logic [T_W_DEFAULT-1:0] rt_tuse;
   } hazard_t;

endpackage

// File: rtl/pipe_stage_reg_if.sv
// Stage-to-stage bus: incoming instruction fields and their registered counterparts.
interface pipe_stage_reg_if #(
   parameter int unsigned PAYLOAD_W = 128,
   parameter int unsigned T_W       = 4
) ();

   logic                 in_valid;
   logic [PAYLOAD_W-1:0] in_payload;
   logic [31:0]          in_pc;
   logic [4:0]           in_dst_addr;
   logic [T_W-1:0]       in_tnew;
   logic [T_W-1:0]       in_rs_tuse;
   logic [T_W-1:0]       in_rt_tuse;

   logic                 out_valid;
   logic [PAYLOAD_W-1:0] out_payload;
   logic [31:0]          out_pc;
   logic [4:0]           out_dst_addr;
   logic [T_W-1:0]       out_tnew;
   logic [T_W-1:0]       out_rs_tuse;
   logic [T_W-1:0]       out_rt_tuse;

   modport master (
      output in_valid, in_payload, in_pc, in_dst_addr, in_tnew, in_rs_tuse, in_rt_tuse,
      input  out_valid, out_payload, out_pc, out_dst_addr, out_tnew, out_rs_tuse, out_rt_tuse
   );

   modport slave (
      input  in_valid, in_payload, in_pc, in_dst_addr, in_tnew, in_rs_tuse, in_rt_tuse,
      output out_valid, out_payload, out_pc, out_dst_addr, out_tnew, out_rs_tuse, out_rt_tuse
   );

endinterface

// File: rtl/pipe_stage_reg_sat_counter.sv
// Saturating up-counter with asynchronous active-low clear; holds at all-ones.
module sat_counter #(
   parameter int unsigned W = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         inc,
   output logic [W-1:0] count
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (inc && (count != '1)) begin
         count <= count + W'(1);
      end
   end

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic inter-stage pipeline register with valid bit, flush-to-bubble,
// optional Tnew ageing while stalled and a saturating bubble counter.
module pipe_stage_reg
   import pipe_pkg::*;
#(
   parameter int unsigned PAYLOAD_W    = 128,
   parameter int unsigned T_W          = T_W_DEFAULT,
   parameter int unsigned TUSE_NONE    = TUSE_NONE_DEFAULT,
   parameter int unsigned AGE_ON_STALL = 0,
   parameter int unsigned CNT_W        = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   input  logic             flush,
   pipe_stage_reg_if.slave  bus,
   output logic [CNT_W-1:0] bubble_cnt
);

   localparam logic [T_W-1:0] TUSE_IDLE = T_W'(TUSE_NONE);

   logic                 valid_q;
   logic [PAYLOAD_W-1:0] payload_q;
   logic [31:0]          pc_q;
   logic [4:0]           dst_q;
   logic [T_W-1:0]       tnew_q;
   logic [T_W-1:0]       rs_tuse_q;
   logic [T_W-1:0]       rt_tuse_q;

   // Priority: async reset, flush, load, hold (with optional Tnew ageing).
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         valid_q   <= 1'b0;
         payload_q <= '0;
         pc_q      <= '0;
         dst_q     <= GPR_ZERO;
         tnew_q    <= '0;
         rs_tuse_q <= TUSE_IDLE;
         rt_tuse_q <= TUSE_IDLE;
      end else if (flush) begin
         valid_q   <= 1'b0;
         payload_q <= '0;
         pc_q      <= '0;
         dst_q     <= GPR_ZERO;
         tnew_q    <= '0;
         rs_tuse_q <= TUSE_IDLE;
         rt_tuse_q <= TUSE_IDLE;
      end else if (enable) begin
         valid_q <= bus.in_valid;
         pc_q    <= bus.in_pc;
         if (bus.in_valid) begin
            payload_q <= bus.in_payload;
            dst_q     <= bus.in_dst_addr;
            // $0 never forwards, so its result is treated as already available
            tnew_q    <= (bus.in_dst_addr == GPR_ZERO) ? '0 : bus.in_tnew;
            rs_tuse_q <= bus.in_rs_tuse;
            rt_tuse_q <= bus.in_rt_tuse;
         end else begin
            payload_q <= '0;
            dst_q     <= GPR_ZERO;
            tnew_q    <= '0;
            rs_tuse_q <= TUSE_IDLE;
            rt_tuse_q <= TUSE_IDLE;
         end
      end else if ((AGE_ON_STALL != 0) && (tnew_q != '0)) begin
         tnew_q <= tnew_q - T_W'(1);
      end
   end

   // Only locally inserted bubbles are counted; upstream bubbles were counted upstream.
   sat_counter #(
      .W (CNT_W)
   ) u_bubble_cnt (
      .clk   (clk),
      .rst_n (reset),
      .inc   (flush),
      .count (bubble_cnt)
   );

   assign bus.out_valid    = valid_q;
   assign bus.out_payload  = payload_q;
   assign bus.out_pc       = pc_q;
   assign bus.out_dst_addr = dst_q;
   assign bus.out_tnew     = (tnew_q == '0) ? '0 : (tnew_q - T_W'(1));
   assign bus.out_rs_tuse  = rs_tuse_q;
   assign bus.out_rt_tuse  = rt_tuse_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Randomized self-checking bench: three stage registers (no ageing, ageing, 2-bit counter)
// driven in parallel and compared against a behavioural model of the stage rules.
module tb_pipe_stage_reg;

   localparam int unsigned PW = 128;
   localparam int unsigned TW = 4;
   localparam int unsigned ND = 3;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          enable = 1'b0;
   logic          flush = 1'b0;
   logic          in_valid = 1'b0;
   logic [PW-1:0] in_payload = '0;
   logic [31:0]   in_pc = '0;
   logic [4:0]    in_dst_addr = '0;
   logic [TW-1:0] in_tnew = '0;
   logic [TW-1:0] in_rs_tuse = '0;
   logic [TW-1:0] in_rt_tuse = '0;

   logic [15:0] cnt0, cnt1;
   logic [1:0]  cnt2;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   pipe_stage_reg_if #(.PAYLOAD_W(PW), .T_W(TW)) if0 ();
   pipe_stage_reg_if #(.PAYLOAD_W(PW), .T_W(TW)) if1 ();
   pipe_stage_reg_if #(.PAYLOAD_W(PW), .T_W(TW)) if2 ();

   assign if0.in_valid = in_valid;    assign if1.in_valid = in_valid;    assign if2.in_valid = in_valid;
   assign if0.in_payload = in_payload; assign if1.in_payload = in_payload; assign if2.in_payload = in_payload;
   assign if0.in_pc = in_pc;          assign if1.in_pc = in_pc;          assign if2.in_pc = in_pc;
   assign if0.in_dst_addr = in_dst_addr; assign if1.in_dst_addr = in_dst_addr; assign if2.in_dst_addr = in_dst_addr;
   assign if0.in_tnew = in_tnew;      assign if1.in_tnew = in_tnew;      assign if2.in_tnew = in_tnew;
   assign if0.in_rs_tuse = in_rs_tuse; assign if1.in_rs_tuse = in_rs_tuse; assign if2.in_rs_tuse = in_rs_tuse;
   assign if0.in_rt_tuse = in_rt_tuse; assign if1.in_rt_tuse = in_rt_tuse; assign if2.in_rt_tuse = in_rt_tuse;

   pipe_stage_reg #(.PAYLOAD_W(PW), .T_W(TW), .TUSE_NONE(4), .AGE_ON_STALL(0), .CNT_W(16)) dut0 (
      .clk(clk), .reset(reset), .enable(enable), .flush(flush), .bus(if0), .bubble_cnt(cnt0));
   pipe_stage_reg #(.PAYLOAD_W(PW), .T_W(TW), .TUSE_NONE(4), .AGE_ON_STALL(1), .CNT_W(16)) dut1 (
      .clk(clk), .reset(reset), .enable(enable), .flush(flush), .bus(if1), .bubble_cnt(cnt1));
   pipe_stage_reg #(.PAYLOAD_W(PW), .T_W(TW), .TUSE_NONE(4), .AGE_ON_STALL(0), .CNT_W(2)) dut2 (
      .clk(clk), .reset(reset), .enable(enable), .flush(flush), .bus(if2), .bubble_cnt(cnt2));

   logic          o_valid   [ND];
   logic [PW-1:0] o_payload [ND];
   logic [31:0]   o_pc      [ND];
   logic [4:0]    o_dst     [ND];
   logic [TW-1:0] o_tnew    [ND];
   logic [TW-1:0] o_rs      [ND];
   logic [TW-1:0] o_rt      [ND];
   logic [15:0]   o_cnt     [ND];

   assign o_valid[0] = if0.out_valid;     assign o_valid[1] = if1.out_valid;     assign o_valid[2] = if2.out_valid;
   assign o_payload[0] = if0.out_payload; assign o_payload[1] = if1.out_payload; assign o_payload[2] = if2.out_payload;
   assign o_pc[0] = if0.out_pc;           assign o_pc[1] = if1.out_pc;           assign o_pc[2] = if2.out_pc;
   assign o_dst[0] = if0.out_dst_addr;    assign o_dst[1] = if1.out_dst_addr;    assign o_dst[2] = if2.out_dst_addr;
   assign o_tnew[0] = if0.out_tnew;       assign o_tnew[1] = if1.out_tnew;       assign o_tnew[2] = if2.out_tnew;
   assign o_rs[0] = if0.out_rs_tuse;      assign o_rs[1] = if1.out_rs_tuse;      assign o_rs[2] = if2.out_rs_tuse;
   assign o_rt[0] = if0.out_rt_tuse;      assign o_rt[1] = if1.out_rt_tuse;      assign o_rt[2] = if2.out_rt_tuse;
   assign o_cnt[0] = cnt0;                assign o_cnt[1] = cnt1;                assign o_cnt[2] = {14'd0, cnt2};

   // Reference model: what each stage holds, in plain integers.
   typedef struct {
      bit            valid;
      logic [PW-1:0] payload;
      logic [31:0]   pc;
      int            dst;
      int            tnew;
      int            rs;
      int            rt;
      int            cnt;
   } mstate_t;

   mstate_t m [ND];
   int      ages [ND] = '{0, 1, 0};
   int      cmax [ND] = '{65535, 65535, 3};

   task automatic check(input string tag, input logic [PW-1:0] got, input logic [PW-1:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic mstate_t make_bubble(input mstate_t s, input logic [31:0] pc);
      mstate_t r;
      r         = s;
      r.valid   = 1'b0;
      r.payload = '0;
      r.pc      = pc;
      r.dst     = 0;
      r.tnew    = 0;
      r.rs      = 4;
      r.rt      = 4;
      return r;
   endfunction

   task automatic model_reset();
      for (int k = 0; k < ND; k++) begin
         m[k]     = make_bubble(m[k], 32'd0);
         m[k].cnt = 0;
      end
   endtask

   task automatic model_edge();
      for (int k = 0; k < ND; k++) begin
         if (flush) begin
            m[k]     = make_bubble(m[k], 32'd0);
            m[k].cnt = (m[k].cnt < cmax[k]) ? m[k].cnt + 1 : cmax[k];
         end else if (enable) begin
            if (in_valid) begin
               m[k].valid   = 1'b1;
               m[k].payload = in_payload;
               m[k].pc      = in_pc;
               m[k].dst     = int'(in_dst_addr);
               m[k].tnew    = (in_dst_addr == 5'd0) ? 0 : int'(in_tnew);
               m[k].rs      = int'(in_rs_tuse);
               m[k].rt      = int'(in_rt_tuse);
            end else begin
               m[k] = make_bubble(m[k], in_pc);
            end
         end else if (ages[k] != 0 && m[k].tnew > 0) begin
            m[k].tnew = m[k].tnew - 1;
         end
      end
   endtask

   task automatic check_all(input string ph);
      int et;
      for (int k = 0; k < ND; k++) begin
         et = (m[k].tnew > 0) ? m[k].tnew - 1 : 0;
         check($sformatf("%s_d%0d_valid", ph, k), PW'(o_valid[k]), PW'(m[k].valid));
         check($sformatf("%s_d%0d_payload", ph, k), o_payload[k], m[k].payload);
         check($sformatf("%s_d%0d_pc", ph, k), PW'(o_pc[k]), PW'(m[k].pc));
         check($sformatf("%s_d%0d_dst", ph, k), PW'(o_dst[k]), PW'(m[k].dst));
         check($sformatf("%s_d%0d_tnew", ph, k), PW'(o_tnew[k]), PW'(et));
         check($sformatf("%s_d%0d_rs", ph, k), PW'(o_rs[k]), PW'(m[k].rs));
         check($sformatf("%s_d%0d_rt", ph, k), PW'(o_rt[k]), PW'(m[k].rt));
         check($sformatf("%s_d%0d_cnt", ph, k), PW'(o_cnt[k]), PW'(m[k].cnt));
      end
   endtask

   // One clock: inputs already set at the falling edge; model tracks the rising edge.
   task automatic step(input string ph);
      @(posedge clk);
      if (reset) model_edge();
      @(negedge clk);
      check_all(ph);
   endtask

   task automatic set_load(input bit v, input logic [4:0] d, input logic [TW-1:0] t,
                           input logic [TW-1:0] rs, input logic [TW-1:0] rt);
      enable      = 1'b1;
      flush       = 1'b0;
      in_valid    = v;
      in_dst_addr = d;
      in_tnew     = t;
      in_rs_tuse  = rs;
      in_rt_tuse  = rt;
      in_payload  = {$urandom(), $urandom(), $urandom(), $urandom()};
      in_pc       = $urandom();
   endtask

   task automatic async_reset(input string ph);
      #2 reset = 1'b0;
      #1 model_reset();
      check_all(ph);
      @(negedge clk);
      reset = 1'b1;
   endtask

   initial begin
      model_reset();
      #12;
      check_all("rst");
      check("rst_tuse_const", PW'(o_rs[0]), PW'(4));
      @(negedge clk);
      reset = 1'b1;

      // Basic load and the $0 destination rule
      set_load(1'b1, 5'd8, 4'd2, 4'd0, 4'd3);
      step("load8");
      check("load8_tnew_const", PW'(o_tnew[0]), PW'(1));
      check("load8_dst_const", PW'(o_dst[0]), PW'(8));
      set_load(1'b1, 5'd0, 4'd3, 4'd1, 4'd1);
      step("load0");
      check("load0_tnew_const", PW'(o_tnew[0]), PW'(0));

      // Stall three cycles after loading Tnew=3
      set_load(1'b1, 5'd5, 4'd3, 4'd1, 4'd2);
      step("ld3");
      enable = 1'b0;
      step("stall1");
      check("stall1_noage", PW'(o_tnew[0]), PW'(2));
      check("stall1_age", PW'(o_tnew[1]), PW'(1));
      step("stall2");
      check("stall2_age", PW'(o_tnew[1]), PW'(0));
      step("stall3");
      check("stall3_noage", PW'(o_tnew[0]), PW'(2));
      check("stall3_age", PW'(o_tnew[1]), PW'(0));

      // Reset mid-stall with a known payload
      set_load(1'b1, 5'd9, 4'd4, 4'd2, 4'd2);
      in_payload = {4{32'hDEAD_BEEF}};
      step("dead");
      enable = 1'b0;
      async_reset("midrst");
      check("midrst_valid_const", PW'(o_valid[0]), PW'(0));
      check("midrst_tuse_const", PW'(o_rt[1]), PW'(4));

      // Five flushes with enable high, then an upstream bubble, then a sixth flush
      enable = 1'b1;
      in_valid = 1'b1;
      in_dst_addr = 5'd3;
      flush  = 1'b1;
      for (int i = 0; i < 5; i++) step("flush");
      set_load(1'b0, 5'd7, 4'd5, 4'd1, 4'd1);
      step("upbub");
      check("upbub_cnt5", PW'(o_cnt[0]), PW'(5));
      check("upbub_cnt_sat", PW'(o_cnt[2]), PW'(3));
      check("upbub_tuse", PW'(o_rs[0]), PW'(4));
      flush = 1'b1;
      step("flush6");
      check("flush6_cnt_sat", PW'(o_cnt[2]), PW'(3));

      // Randomized traffic with occasional async resets
      for (int i = 0; i < 600; i++) begin
         set_load($urandom_range(0, 3) != 0,
                  ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom_range(1, 31)),
                  4'($urandom_range(0, 15)), 4'($urandom_range(0, 4)), 4'($urandom_range(0, 4)));
         enable = ($urandom_range(0, 9) < 6);
         flush  = ($urandom_range(0, 9) == 0);
         if ($urandom_range(0, 79) == 0) async_reset("rndrst");
         step("rnd");
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised inter-stage pipeline register for the five-stage MIPS core, the generalised successor to the fixed-field ID/EX latch. It carries an opaque control/data payload plus the hazard-tracking fields (destination address, Tnew, Rs/Rt Tuse) between any two adjacent stages. It adds a valid bit, flush-to-bubble, an optional in-place Tnew ageing mode for stalled multi-cycle stages, and a saturating bubble counter for the stall/flush statistics.

## Interface
Parameters:
- PAYLOAD_W, 128, width of the opaque payload (ALUop, operands, immediates, ...)
- T_W, 4, width of Tnew/Tuse fields
- TUSE_NONE, 4, Tuse value meaning "register not read"
- AGE_ON_STALL, 0, 1 = stored Tnew decrements on each stalled cycle
- CNT_W, 16, bubble counter width

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-low; clears all state immediately
- enable  in  1  1 = load inputs at edge; 0 = hold (stall)
- flush  in  1  1 = load a bubble at edge, regardless of enable
- in_valid  in  1  incoming instruction is real
- in_payload  in  PAYLOAD_W  payload
- in_pc  in  32  instruction PC
- in_dst_addr  in  5  destination GPR
- in_tnew  in  T_W  cycles until result available, as seen by this stage's input
- in_rs_tuse / in_rt_tuse  in  T_W  source use times
- out_valid  out  1  registered valid
- out_payload  out  PAYLOAD_W  registered payload
- out_pc  out  32  registered PC
- out_dst_addr  out  5  registered destination
- out_tnew  out  T_W  next-stage Tnew: stored==0 ? 0 : stored-1
- out_rs_tuse / out_rt_tuse  out  T_W  registered Tuse
- bubble_cnt  out  CNT_W  bubbles inserted since reset

## Operation
- Priority per edge: reset (async) > flush > enable > hold.
- Reset (reset low): valid=0, payload=0, pc=0, dst=0, stored Tnew=0, Tuse=TUSE_NONE, bubble_cnt=0; so out_tnew=0.
- Flush: load bubble — same values as reset except bubble_cnt, which increments (saturating at all-ones).
- Load (enable=1, flush=0): if in_valid=1, capture all inputs. If in_valid=0, capture as bubble (valid=0, dst=0, Tnew=0, Tuse=TUSE_NONE, payload=0, pc=in_pc) and do NOT increment bubble_cnt (upstream bubble, already counted).
- Load with in_valid=1 and in_dst_addr=0: stored Tnew forced 0 ($0 never forwards).
- Hold (enable=0, flush=0): all fields kept; if AGE_ON_STALL=1 and stored Tnew≠0, stored Tnew decrements by 1; never below 0.
- out_tnew is combinational from stored Tnew (saturating minus one); all other outputs are direct register outputs.
- Arithmetic unsigned; no wrap on Tnew or bubble_cnt.

## Timing
- Latency 1 cycle in to out on load.
- reset assertion: outputs reach reset values without a clock edge; deassertion takes effect at next rising edge.
- flush and enable both high: flush wins, bubble loaded.
- Ageing visible on out_tnew the cycle after each stalled edge.
- Reset mid-stall: everything cleared; stall state not remembered.

## Structure
- Shared package pipe_pkg: T_W default, TUSE_NONE, GPR_ZERO=5'd0, typedef for the hazard tuple (dst_addr, tnew, rs_tuse, rt_tuse) so the hazard unit and all stage registers agree.
- One sub-module natural: sat_counter (parametrised width, inc enable, async active-low clear) used for bubble_cnt.

## Test plan
- Reset low mid-run with payload 0xDEAD...: outputs immediately valid=0, out_tnew=0, tuse=4, bubble_cnt=0.
- Load in_valid=1, dst=8, tnew=2, rs_tuse=0 → next cycle out_valid=1, out_dst_addr=8, out_tnew=1, out_rs_tuse=0.
- Load dst=0, tnew=3 → out_tnew=0.
- enable=0 three cycles after loading tnew=3: AGE_ON_STALL=0 → out_tnew stays 2; AGE_ON_STALL=1 → 1, 0, 0.
- flush=1 with enable=1, five times, then in_valid=0 load → out_valid=0, tuse=4, bubble_cnt=5 (unchanged by the invalid load).
- CNT_W=2, six flushes → bubble_cnt saturates at 3.
